// File: rtl/atomic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atomic_pkg
// Description : Shared types and constants for the RV32A atomic sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package atomic_pkg;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } atomic_state_e;

    localparam logic [31:0] SC_FAIL = 32'd1;

    function automatic logic is_legal_op(input logic [4:0] f5);
        case (f5)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR,
            AMO_AND, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : amo_alu
// Description : Combinational read-modify-write operator for AMO instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module amo_alu
    import atomic_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  amo_op_e         i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_new
);

    // Comparisons keep the old value on ties.
    always_comb begin
        o_new = i_old;
        case (i_op)
            AMO_ADD:  o_new = i_old + i_rs2;
            AMO_SWAP: o_new = i_rs2;
            AMO_XOR:  o_new = i_old ^ i_rs2;
            AMO_AND:  o_new = i_old & i_rs2;
            AMO_OR:   o_new = i_old | i_rs2;
            AMO_MIN:  if ($signed(i_rs2) < $signed(i_old)) o_new = i_rs2;
            AMO_MAX:  if ($signed(i_rs2) > $signed(i_old)) o_new = i_rs2;
            AMO_MINU: if (i_rs2 < i_old) o_new = i_rs2;
            AMO_MAXU: if (i_rs2 > i_old) o_new = i_rs2;
            default:  o_new = i_old;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/atomic_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : atomic_unit_ctrl
// Description : LR/SC/AMO sequencer with reservation tracking and a
//               single-word request/acknowledge memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module atomic_unit_ctrl
    import atomic_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              is_atomic_mem,
    input  logic [4:0]        amo_funct5,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [XLEN-1:0]   rs2_data_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    input  logic              snoop_st_valid,
    input  logic [ADDR_W-1:0] snoop_st_addr,
    output logic              atomic_unit_stall,
    output logic [XLEN-1:0]   result,
    output logic              result_valid,
    output logic              misaligned,
    output logic              illegal_op
);

    localparam logic [ADDR_W-1:0] c_word_mask = ~ADDR_W'(3);

    atomic_state_e     r_state;
    atomic_state_e     w_next_state;
    amo_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_old;
    logic [XLEN-1:0]   r_result;
    logic              r_misaligned;
    logic              r_illegal;
    logic              r_resv_valid;
    logic [ADDR_W-1:0] r_resv_addr;
    logic [XLEN-1:0]   w_alu_new;

    logic              w_misal;
    logic              w_legal;
    logic              w_is_sc;
    logic              w_snoop_hit;
    logic              w_sc_ok;

    assign w_misal     = |addr_mem[1:0];
    assign w_legal     = is_legal_op(amo_funct5);
    assign w_is_sc     = (amo_funct5 == AMO_SC);
    assign w_snoop_hit = snoop_st_valid && r_resv_valid &&
                         ((snoop_st_addr & c_word_mask) == r_resv_addr);
    // A store snooped in the SC accept cycle wins over the reservation.
    assign w_sc_ok     = r_resv_valid && !w_snoop_hit &&
                         ((addr_mem & c_word_mask) == r_resv_addr);

    amo_alu #(.XLEN(XLEN)) u_amo_alu (
        .i_op  (r_op),
        .i_old (r_old),
        .i_rs2 (r_rs2),
        .o_new (w_alu_new)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state      = r_state;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        result_valid      = 1'b0;
        atomic_unit_stall = is_atomic_mem && (r_state != ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (is_atomic_mem) begin
                    if (w_misal || !w_legal) w_next_state = ST_DONE;
                    else if (w_is_sc)        w_next_state = w_sc_ok ? ST_WRITE : ST_DONE;
                    else                     w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                mem_req = 1'b1;
                if (mem_ack) w_next_state = (r_op == AMO_LR) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign mem_addr   = r_addr & c_word_mask;
    assign mem_wdata  = (r_op == AMO_SC || r_op == AMO_SWAP) ? r_rs2 : w_alu_new;
    assign result     = result_valid ? r_result : '0;
    assign misaligned = result_valid && r_misaligned;
    assign illegal_op = result_valid && r_illegal;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op         <= AMO_ADD;
            r_addr       <= '0;
            r_rs2        <= '0;
            r_old        <= '0;
            r_result     <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_atomic_mem) begin
                        r_op         <= amo_op_e'(amo_funct5);
                        r_addr       <= addr_mem;
                        r_rs2        <= rs2_data_mem;
                        r_misaligned <= w_misal;
                        r_illegal    <= !w_legal;
                        r_result     <= (w_is_sc && !w_misal && !w_sc_ok) ? XLEN'(SC_FAIL) : '0;
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        r_old <= mem_rdata;
                        if (r_op == AMO_LR) r_result <= mem_rdata;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) r_result <= (r_op == AMO_SC) ? '0 : r_old;
                end
                default: ;
            endcase

            // Later assignments take priority: clears override an LR set.
            if (r_state == ST_READ && mem_ack && r_op == AMO_LR) begin
                r_resv_valid <= 1'b1;
                r_resv_addr  <= r_addr & c_word_mask;
            end
            if (r_state == ST_IDLE && is_atomic_mem && w_is_sc)
                r_resv_valid <= 1'b0;
            if (r_state == ST_WRITE && mem_ack && r_op != AMO_SC &&
                (r_addr & c_word_mask) == r_resv_addr)
                r_resv_valid <= 1'b0;
            if (w_snoop_hit)
                r_resv_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atomic_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_atomic_unit_ctrl
// Description : Directed self-checking bench for atomic_unit_ctrl with a
//               word-addressed memory responder and programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atomic_unit_ctrl;
    import atomic_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        is_atomic_mem;
    logic [4:0]  amo_funct5;
    logic [31:0] addr_mem;
    logic [31:0] rs2_data_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        snoop_st_valid;
    logic [31:0] snoop_st_addr;
    logic        atomic_unit_stall;
    logic [31:0] result;
    logic        result_valid;
    logic        misaligned;
    logic        illegal_op;

    atomic_unit_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .is_atomic_mem     (is_atomic_mem),
        .amo_funct5        (amo_funct5),
        .addr_mem          (addr_mem),
        .rs2_data_mem      (rs2_data_mem),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .snoop_st_valid    (snoop_st_valid),
        .snoop_st_addr     (snoop_st_addr),
        .atomic_unit_stall (atomic_unit_stall),
        .result            (result),
        .result_valid      (result_valid),
        .misaligned        (misaligned),
        .illegal_op        (illegal_op)
    );

    always #5 clk = ~clk;

    // Memory responder: ack after wait_cfg cycles of request.
    logic [31:0] mem [0:255];
    int          wait_cfg = 0;
    int          wcnt     = 0;
    int          n_req    = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    always_comb begin
        mem_ack   = mem_req && (wcnt >= wait_cfg);
        mem_rdata = mem[mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr[9:2]] <= poke_data;
        if (mem_req) n_req <= n_req + 1;
        if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Issue one atomic, hold it while stalled, report what completed.
    task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                          input logic snp, output logic [31:0] res, output int cyc,
                          output int stl, output logic mis, output logic ill, output int reqs);
        logic got;
        int   req0;
        got  = 1'b0;
        cyc  = 0;
        stl  = 0;
        res  = '0;
        mis  = 1'b0;
        ill  = 1'b0;
        @(negedge clk);
        req0           = n_req;
        is_atomic_mem  = 1'b1;
        amo_funct5     = f5;
        addr_mem       = a;
        rs2_data_mem   = d;
        snoop_st_valid = snp;
        snoop_st_addr  = a;
        for (int i = 0; i < 64 && !got; i++) begin
            if (i > 0) begin
                @(negedge clk);
                snoop_st_valid = 1'b0;
            end
            #1;
            cyc++;
            if (atomic_unit_stall) stl++;
            if (result_valid) begin
                got = 1'b1;
                res = result;
                mis = misaligned;
                ill = illegal_op;
            end
        end
        is_atomic_mem  = 1'b0;
        snoop_st_valid = 1'b0;
        check("op_completes", {31'd0, got}, 32'd1);
        reqs = n_req - req0;
    endtask

    typedef struct {
        logic [4:0]  f5;
        logic [31:0] rs2;
        logic [31:0] exp_new;
    } amo_vec_t;

    amo_vec_t tbl[6];

    logic [31:0] res;
    int          cyc, stl, reqs, req0;
    logic        mis, ill;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        is_atomic_mem  = 1'b0;
        amo_funct5     = '0;
        addr_mem       = '0;
        rs2_data_mem   = '0;
        snoop_st_valid = 1'b0;
        snoop_st_addr  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_stall", {31'd0, atomic_unit_stall}, 32'd0);
        check("rst_result", result, 32'd0);
        reset_n = 1'b1;

        // LR with one wait state
        poke(32'h100, 32'h5);
        wait_cfg = 1;
        run_op(AMO_LR, 32'h100, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("lr_result", res, 32'h5);
        check("lr_cycles", cyc, 4);
        check("lr_stall", stl, 3);
        wait_cfg = 0;

        // SC succeeds on the reservation
        run_op(AMO_SC, 32'h100, 32'hAA, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("sc_ok_result", res, 32'h0);
        check("sc_ok_cycles", cyc, 3);
        check("sc_ok_waddr", last_waddr, 32'h100);
        check("sc_ok_wdata", last_wdata, 32'hAA);
        check("sc_ok_mem", mem[8'h40], 32'hAA);

        // SC consumed the reservation
        run_op(AMO_SC, 32'h100, 32'hBB, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("sc_again_result", res, 32'h1);
        check("sc_again_cycles", cyc, 2);
        check("sc_again_reqs", reqs, 0);

        // Snooped store between LR and SC
        run_op(AMO_LR, 32'h100, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("lr2_result", res, 32'hAA);
        snoop_st_valid = 1'b1;
        snoop_st_addr  = 32'h102;
        @(negedge clk);
        snoop_st_valid = 1'b0;
        run_op(AMO_SC, 32'h100, 32'h55, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("sc_snoop_result", res, 32'h1);
        check("sc_snoop_reqs", reqs, 0);
        check("sc_snoop_mem", mem[8'h40], 32'hAA);

        // Snoop in the SC accept cycle
        run_op(AMO_LR, 32'h100, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        run_op(AMO_SC, 32'h100, 32'h66, 1'b1, res, cyc, stl, mis, ill, reqs);
        check("sc_samecyc_result", res, 32'h1);
        check("sc_samecyc_cycles", cyc, 2);

        // AMOMIN / AMOMINU / AMOADD
        poke(32'h200, 32'hFFFFFFFF);
        run_op(AMO_MIN, 32'h200, 32'h1, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("min_result", res, 32'hFFFFFFFF);
        check("min_wdata", last_wdata, 32'hFFFFFFFF);
        check("min_cycles", cyc, 4);
        run_op(AMO_MINU, 32'h200, 32'h1, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("minu_result", res, 32'hFFFFFFFF);
        check("minu_wdata", last_wdata, 32'h1);
        poke(32'h204, 32'hFFFFFFFF);
        run_op(AMO_ADD, 32'h204, 32'h2, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("add_result", res, 32'hFFFFFFFF);
        check("add_wdata", last_wdata, 32'h1);
        check("add_waddr", last_waddr, 32'h204);

        // Remaining AMO operators, old = 0xF0F0F0F0
        tbl[0] = '{AMO_XOR,  32'h0FF00FF0, 32'hFF00FF00};
        tbl[1] = '{AMO_AND,  32'h0FF00FF0, 32'h00F000F0};
        tbl[2] = '{AMO_OR,   32'h0FF00FF0, 32'hFFF0FFF0};
        tbl[3] = '{AMO_SWAP, 32'h0FF00FF0, 32'h0FF00FF0};
        tbl[4] = '{AMO_MAXU, 32'h0FF00FF0, 32'hF0F0F0F0};
        tbl[5] = '{AMO_MAX,  32'h0FF00FF0, 32'h0FF00FF0};
        for (int k = 0; k < 6; k++) begin
            poke(32'h20C, 32'hF0F0F0F0);
            run_op(tbl[k].f5, 32'h20C, tbl[k].rs2, 1'b0, res, cyc, stl, mis, ill, reqs);
            check($sformatf("amo%0d_result", k), res, 32'hF0F0F0F0);
            check($sformatf("amo%0d_wdata", k), last_wdata, tbl[k].exp_new);
        end

        // Misaligned and illegal
        run_op(AMO_LR, 32'h102, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("mis_flag", {31'd0, mis}, 32'd1);
        check("mis_cycles", cyc, 2);
        check("mis_reqs", reqs, 0);
        run_op(5'b00101, 32'h100, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("ill_flag", {31'd0, ill}, 32'd1);
        check("ill_mis", {31'd0, mis}, 32'd0);
        check("ill_cycles", cyc, 2);

        // AMO write to the reserved word clears it; to another word does not
        run_op(AMO_LR, 32'h300, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        run_op(AMO_SWAP, 32'h300, 32'h7, 1'b0, res, cyc, stl, mis, ill, reqs);
        run_op(AMO_SC, 32'h300, 32'h8, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("sc_after_amo_same", res, 32'h1);
        run_op(AMO_LR, 32'h300, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        run_op(AMO_SWAP, 32'h304, 32'h7, 1'b0, res, cyc, stl, mis, ill, reqs);
        run_op(AMO_SC, 32'h300, 32'h9, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("sc_after_amo_other", res, 32'h0);
        check("sc_after_amo_wdata", last_wdata, 32'h9);

        // Reset while an AMO waits in READ clears the reservation
        run_op(AMO_LR, 32'h100, 32'h0, 1'b0, res, cyc, stl, mis, ill, reqs);
        wait_cfg = 5;
        @(negedge clk);
        req0          = n_req;
        is_atomic_mem = 1'b1;
        amo_funct5    = AMO_ADD;
        addr_mem      = 32'h3F0;
        rs2_data_mem  = 32'h1;
        @(negedge clk);
        #1;
        check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_req_after", {31'd0, mem_req}, 32'd0);
        check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        is_atomic_mem = 1'b0;
        reset_n       = 1'b1;
        wait_cfg      = 0;
        run_op(AMO_SC, 32'h100, 32'h77, 1'b0, res, cyc, stl, mis, ill, reqs);
        check("rst_mid_sc_fail", res, 32'h1);
        check("rst_mid_sc_reqs", reqs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atomic_unit_ctrl.md
# atomic_unit_ctrl

Sequencer for RV32A atomics in the MEM stage. Accepts one LR/SC/AMO at a time and drives a single-word request/acknowledge port to data memory. Performs the read-modify-write and holds the LR reservation. Raises `atomic_unit_stall` toward the hazard handler for the whole operation, then presents the rd result for one cycle.

## Interface
- `ADDR_W`, default 32: byte address width.
- `XLEN`, default 32: data width; only 32 is supported.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `is_atomic_mem`  in  1  MEM-stage instruction is an A-extension op.
- `amo_funct5`  in  5  instr[31:27].
- `addr_mem`  in  ADDR_W  effective address (rs1).
- `rs2_data_mem`  in  XLEN  store/operand value.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  ADDR_W  word address, bits [1:0] forced 0.
- `mem_wdata`  out  XLEN  write data.
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`.
- `mem_ack`  in  1  request completed this cycle.
- `snoop_st_valid`  in  1  a non-atomic store commits this cycle.
- `snoop_st_addr`  in  ADDR_W  its address.
- `atomic_unit_stall`  out  1  hold IF..MEM.
- `result`  out  XLEN  rd write-back value, valid when `result_valid`.
- `result_valid`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  with `result_valid`: addr[1:0] != 0, no access made.
- `illegal_op`  out  1  with `result_valid`: unknown funct5, no access made.

## Operation
- States: IDLE, READ, WRITE, DONE. Reset: IDLE; all outputs 0; reservation cleared.
- IDLE, `is_atomic_mem`=1: latch funct5, addr, rs2.
  - Misaligned or illegal funct5: go to DONE with the matching flag.
  - LR (00010): go to READ.
  - SC (00011): if the reservation is valid and its word address matches, go to WRITE. Otherwise go to DONE with result 1.
  - AMO (SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100): go to READ.
- READ: `mem_req`=1, `mem_we`=0.
  - On `mem_ack`, capture `mem_rdata` as `old`.
  - LR: set the reservation to the latched address, result = `old`, go to DONE.
  - AMO: go to WRITE.
- WRITE: `mem_req`=1, `mem_we`=1.
  - `mem_wdata` = rs2 for SC and SWAP; otherwise `amo_alu(op, old, rs2)`.
  - On `mem_ack`, go to DONE.
  - Result: SC returns 0; AMO returns `old`.
- DONE: `result_valid`=1 and stall=0, so the pipeline advances. Next state is IDLE unconditionally; the next instruction is not sampled here.
- `atomic_unit_stall` = `is_atomic_mem` & (state != DONE). It is combinational, so it is high in the accept cycle.
- Reservation clear events:
  - any SC, whether it succeeds or fails;
  - any AMO write to the reserved word;
  - `snoop_st_valid` with a matching word address;
  - reset.
  - A new LR overwrites the reservation.
- ALU arithmetic: ADD wraps mod 2^32. MIN/MAX compare signed, MINU/MAXU compare unsigned. Ties return `old`.

## Timing
- Handshake: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until `mem_ack`. `mem_ack` may arrive in the same cycle as the request. `mem_req` drops in the cycle after ack unless the state is WRITE.
- Latency from accept (zero-wait memory):
  - LR: 3 cycles (IDLE, READ, DONE).
  - AMO: 4 cycles.
  - Successful SC: 3 cycles.
  - Failed SC, misaligned or illegal: 2 cycles.
  - Each memory wait cycle adds 1.
- Snoop and SC in the same accept cycle: the snoop takes effect first, so the SC fails.
- Reset mid-operation: on the next edge go to IDLE, drop `mem_req`, clear the reservation. The in-flight memory write is not retracted.

## Structure
- Package `atomic_pkg` holds:
  - `amo_op_e`: funct5 encodings above;
  - `atomic_state_e`;
  - the `SC_FAIL` = 1 constant.
- Sub-module `amo_alu`: combinational (op, old, rs2) -> new value.
- The FSM, reservation and handshake live in `atomic_unit_ctrl`.

## Test plan
- LR to 0x100 (mem = 0x5) with ack after 1 wait cycle: result 0x5 in the 4th cycle; stall high for 3 cycles; reservation set.
- LR 0x100, then SC 0x100 with rs2 = 0xAA: write 0xAA to 0x100, result 0.
- Repeat with `snoop_st_valid` to 0x100 between LR and SC: SC result 1, no `mem_req`.
- AMOMIN at 0x200, mem = 0xFFFFFFFF, rs2 = 1: writes 0xFFFFFFFF, result 0xFFFFFFFF. AMOMINU on the same values writes 1.
- AMOADD, mem = 0xFFFFFFFF, rs2 = 2: writes 0x1 (wrap), result 0xFFFFFFFF.
- Address 0x102: `misaligned`=1 in 2 cycles with no request. Reset asserted in READ: IDLE next cycle, `mem_req`=0, reservation cleared.
